// File: rtl/sram_1rw_requester_if.sv
// Request/response streams and 1RW macro port bundle for sram_1rw_requester.
// master = the requester block, slave = its surroundings (pipeline, consumer, macro).
interface sram_1rw_requester_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_en;
    logic              mem_wmode;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, mem_addr, mem_en, mem_wmode, mem_wdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, mem_addr, mem_en, mem_wmode, mem_wdata
    );
endinterface

// File: rtl/sram_1rw_requester.sv
// Drives a 1RW SRAM macro from a valid/ready request stream and buffers read data in a
// credit-managed response FIFO. Define SRAM_1RW_REQ_BYPASS_EN for 1-cycle read latency.
module sram_1rw_requester #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 64,
    parameter int RESP_DEPTH = 4
) (
    input logic                  clock,
    input logic                  reset_n,
    sram_1rw_requester_if.master bus
);
    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(RESP_DEPTH - 1);
    localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(RESP_DEPTH);

    if (RESP_DEPTH < 2) begin : g_bad_depth
        $error("sram_1rw_requester: RESP_DEPTH must be at least 2");
    end

    logic [DATA_W-1:0] fifo_mem [RESP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic              rd_pend;

    logic fifo_empty;
    logic has_credit;
    logic req_fire;
    logic rd_accept;
    logic fifo_enq;
    logic fifo_deq;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    endfunction

    always_comb begin
        // NOTE: every signal gets a value before any conditional override, so no latch is inferred.
        fifo_empty = (fifo_count == '0);
        // A read needs a guaranteed FIFO slot: buffered entries plus the read still in the macro.
        has_credit = ({1'b0, fifo_count} + (CNT_W + 1)'(rd_pend)) < DEPTH_EXT;

        bus.req_ready = reset_n & (bus.req_write | has_credit);
        req_fire      = bus.req_valid & bus.req_ready;
        rd_accept     = req_fire & ~bus.req_write;

        bus.mem_en    = req_fire;
        bus.mem_wmode = bus.req_write;
        bus.mem_addr  = bus.req_addr;
        bus.mem_wdata = bus.req_wdata;

        bus.resp_valid = ~fifo_empty;
        bus.resp_rdata = fifo_mem[rd_ptr];
        fifo_enq       = rd_pend;
        fifo_deq       = ~fifo_empty & bus.resp_ready;
`ifdef SRAM_1RW_REQ_BYPASS_EN
        // Empty FIFO: present the macro data directly and only buffer it if not taken now.
        if (rd_pend && fifo_empty) begin
            bus.resp_valid = 1'b1;
            bus.resp_rdata = bus.mem_rdata;
            fifo_enq       = ~bus.resp_ready;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            rd_pend    <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            rd_pend <= rd_accept;
            if (fifo_enq) wr_ptr <= ptr_inc(wr_ptr);
            if (fifo_deq) rd_ptr <= ptr_inc(rd_ptr);
            case ({fifo_enq, fifo_deq})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // NOTE: FIFO storage is not reset; an entry is only presented after it has been written.
    always_ff @(posedge clock) begin
        if (fifo_enq) fifo_mem[wr_ptr] <= bus.mem_rdata;
    end
endmodule

// File: tb/tb_sram_1rw_requester.sv
// Drives two requesters (RESP_DEPTH 4 and 3) from one stimulus stream and checks them
// against a transaction-level scoreboard of expected read data and release cycles.
module tb_sram_1rw_requester;
`ifdef SRAM_1RW_REQ_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif
    localparam int N  = 2;
    localparam int D0 = 4;
    localparam int D1 = 3;

    typedef struct packed {
        logic [63:0] data;
        int          avail;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [63:0] req_wdata;
    logic        resp_ready;

    always #5 clock = ~clock;

    sram_1rw_requester_if #(.ADDR_W(8), .DATA_W(64)) bus0 ();
    sram_1rw_requester_if #(.ADDR_W(8), .DATA_W(64)) bus1 ();

    assign bus0.req_valid  = req_valid;
    assign bus0.req_write  = req_write;
    assign bus0.req_addr   = req_addr;
    assign bus0.req_wdata  = req_wdata;
    assign bus0.resp_ready = resp_ready;
    assign bus1.req_valid  = req_valid;
    assign bus1.req_write  = req_write;
    assign bus1.req_addr   = req_addr;
    assign bus1.req_wdata  = req_wdata;
    assign bus1.resp_ready = resp_ready;

    sram_1rw_requester #(.ADDR_W(8), .DATA_W(64), .RESP_DEPTH(D0)) dut0 (
        .clock(clock), .reset_n(reset_n), .bus(bus0.master));
    sram_1rw_requester #(.ADDR_W(8), .DATA_W(64), .RESP_DEPTH(D1)) dut1 (
        .clock(clock), .reset_n(reset_n), .bus(bus1.master));

    // Macro models: synchronous 1RW array, read data valid only the cycle after a read.
    logic [63:0] sram0 [256];
    logic [63:0] sram1 [256];
    logic [63:0] q0, q1;
    logic        qv0 = 1'b0;
    logic        qv1 = 1'b0;

    always @(posedge clock) begin
        qv0 <= bus0.mem_en & ~bus0.mem_wmode;
        qv1 <= bus1.mem_en & ~bus1.mem_wmode;
        if (bus0.mem_en) begin
            if (bus0.mem_wmode) sram0[bus0.mem_addr] <= bus0.mem_wdata;
            else q0 <= sram0[bus0.mem_addr];
        end
        if (bus1.mem_en) begin
            if (bus1.mem_wmode) sram1[bus1.mem_addr] <= bus1.mem_wdata;
            else q1 <= sram1[bus1.mem_addr];
        end
    end
    assign bus0.mem_rdata = qv0 ? q0 : 64'hDEAD_0BAD_0BAD_DEAD;
    assign bus1.mem_rdata = qv1 ? q1 : 64'hDEAD_0BAD_0BAD_DEAD;

    logic        obs_ready [N];
    logic        obs_valid [N];
    logic        obs_en    [N];
    logic        obs_wmode [N];
    logic [7:0]  obs_addr  [N];
    logic [63:0] obs_rdata [N];

    assign obs_ready[0] = bus0.req_ready;
    assign obs_valid[0] = bus0.resp_valid;
    assign obs_en[0]    = bus0.mem_en;
    assign obs_wmode[0] = bus0.mem_wmode;
    assign obs_addr[0]  = bus0.mem_addr;
    assign obs_rdata[0] = bus0.resp_rdata;
    assign obs_ready[1] = bus1.req_ready;
    assign obs_valid[1] = bus1.resp_valid;
    assign obs_en[1]    = bus1.mem_en;
    assign obs_wmode[1] = bus1.mem_wmode;
    assign obs_addr[1]  = bus1.mem_addr;
    assign obs_rdata[1] = bus1.resp_rdata;

    // Reference: architectural memory contents and, per instance, the reads still owed.
    logic [63:0] ref_mem [256];
    exp_t        sb [N][$];
    int          dut_acc [N];
    int          cyc      = 0;
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic int depth_of(input int i);
        return (i == 0) ? D0 : D1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [7:0] a,
                         input logic [63:0] d, input logic rr);
        req_valid  = v;
        req_write  = w;
        req_addr   = a;
        req_wdata  = d;
        resp_ready = rr;
    endtask

    // One clock cycle: check at the falling edge, advance the model, then move past the edge.
    task automatic step();
        @(negedge clock);
        for (int i = 0; i < N; i++) begin
            logic exp_ready;
            logic exp_valid;
            exp_ready = reset_n && (req_write || sb[i].size() < depth_of(i));
            exp_valid = reset_n && sb[i].size() != 0 && cyc >= sb[i][0].avail;
            check($sformatf("req_ready[%0d]", i), 64'(obs_ready[i]), 64'(exp_ready));
            check($sformatf("resp_valid[%0d]", i), 64'(obs_valid[i]), 64'(exp_valid));
            check($sformatf("mem_en[%0d]", i), 64'(obs_en[i]), 64'(req_valid & exp_ready));
            if (exp_valid) check($sformatf("resp_rdata[%0d]", i), obs_rdata[i], sb[i][0].data);
            if (req_valid) begin
                check($sformatf("mem_wmode[%0d]", i), 64'(obs_wmode[i]), 64'(req_write));
                check($sformatf("mem_addr[%0d]", i), 64'(obs_addr[i]), 64'(req_addr));
            end
            if (req_valid && obs_ready[i]) dut_acc[i]++;
            if (exp_valid && resp_ready) void'(sb[i].pop_front());
            if (req_valid && exp_ready && !req_write) begin
                exp_t e;
                e.data  = ref_mem[req_addr];
                e.avail = cyc + LAT;
                sb[i].push_back(e);
            end
        end
        if (reset_n && req_valid && req_write) ref_mem[req_addr] = req_wdata;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n, input logic rr);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, 1'b0, 8'h00, 64'h0, rr);
            step();
        end
    endtask

    initial begin
        int base [N];

        // Reset with a pending write request: nothing may be accepted.
        reset_n = 1'b0;
        drive(1'b1, 1'b1, 8'h05, 64'h1111, 1'b0);
        step();
        step();
        reset_n = 1'b1;

        // Preload addresses 0..15, then the directed pattern.
        for (int a = 0; a < 16; a++) begin
            drive(1'b1, 1'b1, 8'(a), {$urandom, $urandom}, 1'b1);
            step();
        end
        drive(1'b1, 1'b1, 8'h12, 64'hDEAD_BEEF_CAFE_F00D, 1'b1);
        step();
        drive(1'b1, 1'b0, 8'h12, 64'h0, 1'b1);
        step();
        idle(3, 1'b1);

        // Back-to-back reads with a willing consumer: no stalls at either depth.
        for (int i = 0; i < N; i++) base[i] = dut_acc[i];
        for (int a = 0; a < 8; a++) begin
            drive(1'b1, 1'b0, 8'(a), 64'h0, 1'b1);
            step();
        end
        for (int i = 0; i < N; i++)
            check($sformatf("b2b_accepts[%0d]", i), 64'(dut_acc[i] - base[i]), 64'd8);
        idle(3, 1'b1);

        // Stalled consumer: credits limit accepted reads; writes still flow.
        for (int i = 0; i < N; i++) base[i] = dut_acc[i];
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b0, 8'(k + 3), 64'h0, 1'b0);
            step();
        end
        for (int i = 0; i < N; i++)
            check($sformatf("stall_accepts[%0d]", i), 64'(dut_acc[i] - base[i]),
                  64'(depth_of(i)));
        drive(1'b1, 1'b1, 8'h07, {$urandom, $urandom}, 1'b0);
        step();
        idle(5, 1'b0);
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 1'b0, 8'(k), 64'h0, 1'b1);
            step();
        end
        idle(6, 1'b1);

        // Random traffic; toggling consumer first, then a random one.
        for (int k = 0; k < 300; k++) begin
            logic rr;
            rr = (k < 100) ? k[0] : 1'($urandom_range(0, 1));
            drive(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 3),
                  8'($urandom_range(0, 15)), {$urandom, $urandom}, rr);
            step();
        end
        idle(8, 1'b1);

        // Fill the FIFOs with a read still in the macro, then reset mid-cycle.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 8'(k), 64'h0, 1'b0);
            step();
        end
        drive(1'b1, 1'b0, 8'h09, 64'h0, 1'b0);
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("async_req_ready[%0d]", i), 64'(obs_ready[i]), 64'd0);
            check($sformatf("async_resp_valid[%0d]", i), 64'(obs_valid[i]), 64'd0);
            check($sformatf("async_mem_en[%0d]", i), 64'(obs_en[i]), 64'd0);
            sb[i].delete();
        end
        step();
        reset_n = 1'b1;
        idle(1, 1'b0);
        for (int i = 0; i < N; i++) base[i] = dut_acc[i];
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 1'b0, 8'(k + 8), 64'h0, 1'b0);
            step();
        end
        for (int i = 0; i < N; i++)
            check($sformatf("post_reset_accepts[%0d]", i), 64'(dut_acc[i] - base[i]),
                  64'(depth_of(i)));
        idle(8, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
